// File: rtl/pll_reconfig_pkg.sv
// -----------------------------------------------------------------------------
// pll_reconfig_pkg
// Shared definitions for the PLL reconfiguration sequencer:
//   - reconfig core register addresses
//   - profile entry record {addr, data}
//   - per-profile write tables (profile 0 = PAL, profile 1 = NTSC)
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package pll_reconfig_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;
    localparam logic [5:0] ADDR_K     = 6'h07;

    localparam int unsigned ENTRIES_PER_PROFILE = 6;
    localparam logic [2:0]  LAST_ENTRY_IDX      = 3'd5;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } prof_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_WRITE     = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DROP = 3'd4,
        ST_WAIT_LOCK = 3'd5
    } seq_state_t;

    localparam prof_entry_t START_ENTRY = '{addr: ADDR_START, data: 32'h0000_0001};

    // Entry 0 selects waitrequest mode; C0..C2 share the C address and are
    // distinguished by the counter-select field inside the data word.
    localparam prof_entry_t PROFILE_TABLE [2][ENTRIES_PER_PROFILE] = '{
        '{ '{ADDR_MODE, 32'h0000_0000},     // PAL
           '{ADDR_M,    32'h0002_0605},
           '{ADDR_K,    32'h599D_C7FD},
           '{ADDR_C,    32'h0000_0303},
           '{ADDR_C,    32'h0006_0504},
           '{ADDR_C,    32'h0008_0909} },
        '{ '{ADDR_MODE, 32'h0000_0000},     // NTSC
           '{ADDR_M,    32'h0002_0B0A},
           '{ADDR_K,    32'h2E8B_A2E9},
           '{ADDR_C,    32'h0000_0404},
           '{ADDR_C,    32'h0006_0605},
           '{ADDR_C,    32'h0008_0A0A} }
    };

    // Out-of-range indices fall back to the harmless mode write.
    function automatic prof_entry_t profile_entry(input logic prof, input logic [2:0] idx);
        prof_entry_t e;
        if (idx <= LAST_ENTRY_IDX) begin
            e = PROFILE_TABLE[prof][idx];
        end else begin
            e = '{addr: ADDR_MODE, data: 32'h0000_0000};
        end
        return e;
    endfunction

endpackage

// File: rtl/pll_reconfig_seq_avmm_write_master.sv
// -----------------------------------------------------------------------------
// avmm_write_master
// Single-write Avalon-MM handshake engine. A start_i pulse loads addr/data and
// raises write; the bus signals hold until waitrequest drops. complete_o flags
// the accepting cycle, and a start_i in that same cycle chains the next write
// with no idle cycle in between.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start_i           load a new write
//   addr_i, data_i    address/data for the new write
//   waitrequest_i     slave stall
//   complete_o        write accepted this cycle
//   write_o, address_o, writedata_o   Avalon master outputs (registered)
// -----------------------------------------------------------------------------
module avmm_write_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [5:0]  addr_i,
    input  logic [31:0] data_i,
    input  logic        waitrequest_i,
    output logic        complete_o,
    output logic        write_o,
    output logic [5:0]  address_o,
    output logic [31:0] writedata_o
);

    logic        write_q;
    logic [5:0]  address_q;
    logic [31:0] writedata_q;

    assign complete_o  = write_q & ~waitrequest_i;
    assign write_o     = write_q;
    assign address_o   = address_q;
    assign writedata_o = writedata_q;

    // Bus register: load on start, drop write after acceptance, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q     <= 1'b0;
            address_q   <= 6'h00;
            writedata_q <= 32'h0000_0000;
        end else if (start_i) begin
            write_q     <= 1'b1;
            address_q   <= addr_i;
            writedata_q <= data_i;
        end else if (complete_o) begin
            write_q     <= 1'b0;
        end else begin
            write_q     <= write_q;
        end
    end

endmodule

// File: rtl/pll_reconfig_seq.sv
// -----------------------------------------------------------------------------
// pll_reconfig_seq
// Writes a stored clock profile into the PLL reconfig core, starts the
// reconfiguration, then waits for the PLL to drop and regain lock.
// Ports:
//   clk, rst_n         management clock, async active-low reset
//   req, profile       one-cycle request and profile index (0 PAL, 1 NTSC)
//   busy, done, error  status (done one-cycle, error sticky until next req)
//   active_profile     last successfully applied profile
//   pll_locked         PLL lock, asynchronous to clk
//   mgmt_*             Avalon-MM master to the reconfig core
// -----------------------------------------------------------------------------
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_PROFILES   = 2,
    parameter int LOCK_TIMEOUT   = 1000000,
    parameter int LOCK_DROP_WAIT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        profile,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        active_profile,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest
);

    localparam int         CNT_W      = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [1:0] NUM_PROF_C = 2'(NUM_PROFILES);

    seq_state_t       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prof_q, prof_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             active_q, active_d;
    logic [1:0]       lock_sync_q;

    logic             lock_s;
    logic             accept_s;
    logic             bypass_s;
    logic             drop_elapsed_s;
    logic             timeout_s;
    logic             wr_start_s;
    prof_entry_t      wr_entry_s;
    logic             wr_complete_s;

    assign lock_s         = lock_sync_q[1];
    assign accept_s       = req & ~busy_q & ({1'b0, profile} < NUM_PROF_C);
    assign bypass_s       = (prof_q == active_q) & ~error_q & lock_s;
    // Compared one below the limit so the exit edge lands exactly on the limit.
    assign drop_elapsed_s = (cnt_q >= CNT_W'(LOCK_DROP_WAIT - 1));
    assign timeout_s      = (cnt_q >= CNT_W'(LOCK_TIMEOUT - 1));

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign active_profile = active_q;

    avmm_write_master u_wr (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (wr_start_s),
        .addr_i        (wr_entry_s.addr),
        .data_i        (wr_entry_s.data),
        .waitrequest_i (mgmt_waitrequest),
        .complete_o    (wr_complete_s),
        .write_o       (mgmt_write),
        .address_o     (mgmt_address),
        .writedata_o   (mgmt_writedata)
    );

    // State, sequencing and status registers plus the lock synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            cnt_q       <= {CNT_W{1'b0}};
            prof_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            active_q    <= 1'b0;
            lock_sync_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            prof_q      <= prof_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            active_q    <= active_d;
            lock_sync_q <= {lock_sync_q[0], pll_locked};
        end
    end

    // Next-state, entry index and saturating lock-wait counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_CHECK;
                else          state_d = ST_IDLE;
            end
            ST_CHECK: begin
                if (bypass_s) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = 3'd0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_complete_s && (idx_q == LAST_ENTRY_IDX)) state_d = ST_START;
                else if (wr_complete_s)                         idx_d   = idx_q + 3'd1;
                else                                            state_d = ST_WRITE;
            end
            ST_START: begin
                if (wr_complete_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_WAIT_DROP;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_WAIT_DROP, ST_WAIT_LOCK: begin
                // One counter spans both wait states; it saturates, never wraps.
                if (cnt_q != CNT_W'(LOCK_TIMEOUT)) cnt_d = cnt_q + CNT_W'(1);
                else                               cnt_d = cnt_q;
                if (state_q == ST_WAIT_DROP) begin
                    if (!lock_s || drop_elapsed_s) state_d = ST_WAIT_LOCK;
                    else                           state_d = ST_WAIT_DROP;
                end else begin
                    if (lock_s || timeout_s) state_d = ST_IDLE;
                    else                     state_d = ST_WAIT_LOCK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status next values and write-engine commands.
    always_comb begin
        prof_d     = prof_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        active_d   = active_q;
        wr_start_s = 1'b0;
        wr_entry_s = profile_entry(prof_q, 3'd0);
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    prof_d  = profile;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = busy_q;
                end
            end
            ST_CHECK: begin
                if (bypass_s) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    wr_start_s = 1'b1;
                end
            end
            ST_WRITE: begin
                wr_start_s = wr_complete_s;
                if (idx_q == LAST_ENTRY_IDX) wr_entry_s = START_ENTRY;
                else                         wr_entry_s = profile_entry(prof_q, idx_q + 3'd1);
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    active_d = prof_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else if (timeout_s) begin
                    error_d  = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    busy_d   = 1'b1;
                end
            end
            default: begin
                wr_start_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
module tb_pll_reconfig_seq;

    localparam int LOCK_TIMEOUT   = 200;
    localparam int LOCK_DROP_WAIT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        profile = 1'b0;
    logic        spam_req = 1'b0;
    logic        spam_prof = 1'b0;
    logic        dut_req, dut_prof;
    logic        pll_locked = 1'b0;
    logic        mgmt_waitrequest = 1'b0;
    logic        busy, done, error, active_profile, mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;

    always #10 clk = ~clk;

    assign dut_req  = req | spam_req;
    assign dut_prof = spam_req ? spam_prof : profile;

    pll_reconfig_seq #(.NUM_PROFILES(2), .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_DROP_WAIT(LOCK_DROP_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .req(dut_req), .profile(dut_prof),
        .busy(busy), .done(done), .error(error), .active_profile(active_profile),
        .pll_locked(pll_locked), .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest)
    );

    // kind: 0 = write {addr,data}, 1 = done with active_profile, 2 = error with active_profile
    typedef struct { int kind; logic [37:0] wr; logic prof; } exp_t;
    exp_t exp_q[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, start_cyc = -1, done_cyc = -1, last_wr_cyc = -100;
    int n_writes = 0, k_cycles = 0, wr_mode = 0, req_cyc = 0;
    bit model_active = 1'b0, spam_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Expected bus writes of a reconfiguration, entry 6 being the start write.
    function automatic logic [37:0] ref_write(input bit p, input int i);
        case (i)
            0:       return {6'h00, 32'h0000_0000};
            1:       return {6'h04, p ? 32'h0002_0B0A : 32'h0002_0605};
            2:       return {6'h07, p ? 32'h2E8B_A2E9 : 32'h599D_C7FD};
            3:       return {6'h05, p ? 32'h0000_0404 : 32'h0000_0303};
            4:       return {6'h05, p ? 32'h0006_0605 : 32'h0006_0504};
            5:       return {6'h05, p ? 32'h0008_0A0A : 32'h0008_0909};
            default: return {6'h02, 32'h0000_0001};
        endcase
    endfunction

    function automatic exp_t mk(input int kind, input logic [37:0] wr, input logic prof);
        exp_t e;
        e.kind = kind; e.wr = wr; e.prof = prof;
        return e;
    endfunction

    // Waitrequest generator: none, random stalls, or five stall cycles on the K write.
    initial begin : waitreq_gen
        int stall;
        stall = 0;
        forever begin
            @(posedge clk); #1;
            case (wr_mode)
                1: mgmt_waitrequest = ($urandom_range(0, 2) == 0);
                2: begin
                    if (mgmt_write && mgmt_address == 6'h07 && stall < 5) begin
                        mgmt_waitrequest = 1'b1;
                        stall++;
                    end else begin
                        mgmt_waitrequest = 1'b0;
                        if (mgmt_address != 6'h07) stall = 0;
                    end
                end
                default: mgmt_waitrequest = 1'b0;
            endcase
        end
    end

    // Extra requests while busy; all of them must be dropped.
    initial begin : spammer
        forever begin
            @(posedge clk); #1;
            if (spam_en && busy && ($urandom_range(0, 2) == 0)) begin
                spam_req  = 1'b1;
                spam_prof = 1'($urandom_range(0, 1));
            end else begin
                spam_req  = 1'b0;
            end
        end
    end

    // Monitor: compares every bus write, done pulse and error rise against the queue.
    initial begin : monitor
        exp_t e;
        logic prev_hold, prev_err;
        logic [5:0]  h_addr;
        logic [31:0] h_data;
        prev_hold = 1'b0; prev_err = 1'b0; h_addr = 6'h00; h_data = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_hold = 1'b0; prev_err = 1'b0;
                continue;
            end
            if (prev_hold) begin
                check("hold_write", 64'(mgmt_write), 64'd1);
                check("hold_addr_data", {26'd0, mgmt_address, mgmt_writedata}, {26'd0, h_addr, h_data});
            end
            prev_hold = mgmt_write && mgmt_waitrequest;
            h_addr = mgmt_address; h_data = mgmt_writedata;
            if (mgmt_write && mgmt_address == 6'h07) k_cycles++;
            if (mgmt_write && !mgmt_waitrequest) begin
                n_writes++;
                if (wr_mode == 0 && mgmt_address != 6'h00)
                    check("back_to_back_gap", 64'(cyc - last_wr_cyc), 64'd1);
                last_wr_cyc = cyc;
                if (mgmt_address == 6'h02) start_cyc = cyc;
                if (exp_q.size() == 0) fail_now("unexpected_write");
                else begin
                    e = exp_q.pop_front();
                    check("write_kind", 64'(e.kind), 64'd0);
                    check("write_addr_data", {26'd0, mgmt_address, mgmt_writedata}, {26'd0, e.wr});
                end
            end
            if (done) begin
                done_cyc = cyc;
                if (exp_q.size() == 0) fail_now("unexpected_done");
                else begin
                    e = exp_q.pop_front();
                    check("done_kind", 64'(e.kind), 64'd1);
                    check("done_active_profile", 64'(active_profile), 64'(e.prof));
                    check("done_busy_low", 64'(busy), 64'd0);
                end
            end
            if (error && !prev_err) begin
                if (exp_q.size() == 0) fail_now("unexpected_error");
                else begin
                    e = exp_q.pop_front();
                    check("error_kind", 64'(e.kind), 64'd2);
                    check("error_active_profile", 64'(active_profile), 64'(e.prof));
                    check("error_busy_low", 64'(busy), 64'd0);
                    check("timeout_latency", 64'(cyc - start_cyc), 64'(LOCK_TIMEOUT + 1));
                end
            end
            prev_err = error;
        end
    end

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 3000 && busy; i++) begin
            @(posedge clk); #1;
        end
        if (busy) fail_now({name, "_busy_timeout"});
    endtask

    // One request: model the outcome, issue it, then play the PLL lock behaviour.
    task automatic run_seq(input bit p, input bit relock, input bit drop, input int delay, input int mode);
        bit bypass;
        int i;
        wr_mode = mode;
        bypass = (p == model_active) && pll_locked;
        if (bypass) exp_q.push_back(mk(1, 38'd0, p));
        else begin
            for (int k = 0; k < 7; k++) exp_q.push_back(mk(0, ref_write(p, k), 1'b0));
            if (relock) begin
                exp_q.push_back(mk(1, 38'd0, p));
                model_active = p;
            end else begin
                exp_q.push_back(mk(2, 38'd0, model_active));
            end
        end
        start_cyc = -1;
        @(posedge clk); #1;
        req = 1'b1; profile = p; req_cyc = cyc + 1;
        @(posedge clk); #1;
        req = 1'b0;
        if (!bypass) begin
            for (i = 0; i < 1000 && start_cyc < 0; i++) begin
                @(posedge clk); #1;
            end
            if (start_cyc < 0) fail_now("start_write_timeout");
            if (drop) begin
                repeat (3) @(posedge clk);
                #1 pll_locked = 1'b0;
            end
            if (relock) begin
                repeat (delay) @(posedge clk);
                #1 pll_locked = 1'b1;
            end
        end
        wait_idle("seq");
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int w0, i;
        bit p, drop, relock;
        // Reset state.
        #5;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_active", 64'(active_profile), 64'd0);
        check("rst_write", 64'(mgmt_write), 64'd0);
        check("rst_addr_data", {26'd0, mgmt_address, mgmt_writedata}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // PAL from reset, no stalls, lock drops then returns 100 cycles later.
        run_seq(1'b0, 1'b1, 1'b1, 100, 0);
        check("pal_write_count", 64'(n_writes), 64'd7);

        // NTSC with a five-cycle stall on the K write.
        k_cycles = 0;
        run_seq(1'b1, 1'b1, 1'b1, 100, 2);
        check("k_hold_cycles", 64'(k_cycles), 64'd6);
        check("ntsc_write_count", 64'(n_writes), 64'd14);

        // Same profile again while locked: done without any bus write.
        w0 = n_writes;
        run_seq(1'b1, 1'b1, 1'b1, 100, 0);
        check("bypass_no_writes", 64'(n_writes), 64'(w0));
        check("bypass_latency", 64'(done_cyc - req_cyc), 64'd2);

        // Lock never returns: error, active profile kept.
        run_seq(1'b0, 1'b0, 1'b1, 0, 1);
        check("timeout_active_kept", 64'(active_profile), 64'd1);
        pll_locked = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Requests during the sequence are dropped.
        spam_en = 1'b1;
        w0 = n_writes;
        run_seq(1'b0, 1'b1, 1'b1, 60, 1);
        spam_en = 1'b0;
        check("spam_write_count", 64'(n_writes - w0), 64'd7);

        // Random sequences.
        for (i = 0; i < 8; i++) begin
            p = 1'($urandom_range(0, 1));
            drop = pll_locked ? 1'($urandom_range(0, 1)) : 1'b1;
            relock = drop ? ($urandom_range(0, 3) != 0) : 1'b1;
            run_seq(p, relock, drop, $urandom_range(1, 150), $urandom_range(0, 1));
            if (!relock) begin
                pll_locked = 1'($urandom_range(0, 1));
                repeat (5) @(posedge clk);
                #1;
            end
        end

        // Reset during the third write abandons the sequence.
        wr_mode = 0;
        pll_locked = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        p = ~model_active;
        for (int k = 0; k < 7; k++) exp_q.push_back(mk(0, ref_write(p, k), 1'b0));
        req = 1'b1; profile = p;
        @(posedge clk); #1;
        req = 1'b0;
        for (i = 0; i < 100 && !(mgmt_write && mgmt_address == 6'h07); i++) begin
            @(posedge clk); #1;
        end
        if (!(mgmt_write && mgmt_address == 6'h07)) fail_now("third_write_timeout");
        rst_n = 1'b0;
        #1;
        check("rst_mid_write", 64'(mgmt_write), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_active", 64'(active_profile), 64'd0);
        exp_q.delete();
        model_active = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        run_seq(1'b1, 1'b1, 1'b1, 80, 0);
        check("post_reset_active", 64'(active_profile), 64'd1);

        repeat (10) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
